// File: rtl/dense_layer_engine_if.sv
// Memory-side bus of the dense layer engine: operand read ports (x, w, bias)
// and the result write port. The engine is the master, main memory the slave.
interface dense_layer_engine_if #(
   parameter int DATA_W      = 16,
   parameter int NUM_NEURONS = 10,
   parameter int ADDR_W      = 16
);
   logic                          rd_en;
   logic [ADDR_W-1:0]             x_rd_addr;
   logic [ADDR_W-1:0]             w_rd_addr;
   logic [DATA_W-1:0]             x_rd_data;
   logic [NUM_NEURONS*DATA_W-1:0] w_rd_data;
   logic                          b_rd_en;
   logic [ADDR_W-1:0]             b_rd_addr;
   logic [NUM_NEURONS*DATA_W-1:0] b_rd_data;
   logic                          wr_en;
   logic [ADDR_W-1:0]             wr_addr;
   logic [DATA_W-1:0]             wr_data;

   modport master (
      output rd_en, x_rd_addr, w_rd_addr, b_rd_en, b_rd_addr, wr_en, wr_addr, wr_data,
      input  x_rd_data, w_rd_data, b_rd_data
   );

   modport slave (
      input  rd_en, x_rd_addr, w_rd_addr, b_rd_en, b_rd_addr, wr_en, wr_addr, wr_data,
      output x_rd_data, w_rd_data, b_rd_data
   );
endinterface

// File: rtl/dense_layer_engine.sv
// Fully connected layer engine: out[i] = act(b[i] + sum_k x[k]*w[k][i]) for
// NUM_NEURONS neurons in parallel, results written back one per cycle, with
// the argmax of the post-activation outputs reported as class_idx.
module dense_layer_engine #(
   parameter int DATA_W      = 16,
   parameter int FRAC_W      = 8,
   parameter int NUM_NEURONS = 10,
   parameter int MAX_INPUTS  = 784,
   parameter int ADDR_W      = 16,
   localparam int NI_W       = $clog2(MAX_INPUTS + 1),
   localparam int CI_W       = $clog2(NUM_NEURONS)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [NI_W-1:0]      i_n_inputs,
   input  logic                 i_relu_en,
   input  logic [ADDR_W-1:0]    i_x_base,
   input  logic [ADDR_W-1:0]    i_w_base,
   input  logic [ADDR_W-1:0]    i_b_base,
   input  logic [ADDR_W-1:0]    i_out_base,
   dense_layer_engine_if.master mem_if,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [CI_W-1:0]      o_class_idx
);
   localparam int ACC_W  = 2 * DATA_W + $clog2(MAX_INPUTS) + 1;
   localparam int PROD_W = 2 * DATA_W;
   localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] RES_MIN = -RES_MAX - ACC_W'(1);
   localparam logic [CI_W-1:0]         LAST_J  = CI_W'(NUM_NEURONS - 1);

   typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_WRITE, S_DONE} state_t;

   // Full-precision product, sign-extended to the accumulator width.
   function automatic logic signed [ACC_W-1:0] mac_term(input logic signed [DATA_W-1:0] a,
                                                         input logic signed [DATA_W-1:0] b);
      logic signed [PROD_W-1:0] p;
      p = PROD_W'(a) * PROD_W'(b);
      return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
   endfunction

   // Bias aligned to the product scale (Q.2*FRAC_W).
   function automatic logic signed [ACC_W-1:0] bias_ext(input logic signed [DATA_W-1:0] b);
      logic signed [ACC_W-1:0] e;
      e = {{(ACC_W - DATA_W){b[DATA_W-1]}}, b};
      return e <<< FRAC_W;
   endfunction

   // Rescale back to Q.FRAC_W and clamp to the output range.
   function automatic logic signed [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] s;
      s = a >>> FRAC_W;
      if (s > RES_MAX)      return {1'b0, {(DATA_W - 1){1'b1}}};
      else if (s < RES_MIN) return {1'b1, {(DATA_W - 1){1'b0}}};
      else                  return s[DATA_W-1:0];
   endfunction

   // Optional ReLU on the saturated result.
   function automatic logic signed [DATA_W-1:0] act(input logic signed [DATA_W-1:0] v,
                                                    input logic en);
      return (en && v[DATA_W-1]) ? '0 : v;
   endfunction

   state_t                    r_state, w_next;
   logic [NI_W-1:0]           r_n, r_k;
   logic [CI_W-1:0]           r_j, r_best_idx, r_class_idx;
   logic                      r_relu_en;
   logic [ADDR_W-1:0]         r_x_base, r_w_base, r_b_base, r_out_base;
   logic                      r_vld_p1, r_bvld_p1;
   logic signed [ACC_W-1:0]   r_acc [NUM_NEURONS];
   logic signed [DATA_W-1:0]  r_best;
   logic signed [DATA_W-1:0]  w_x;
   logic signed [DATA_W-1:0]  w_w [NUM_NEURONS];
   logic signed [DATA_W-1:0]  w_b [NUM_NEURONS];
   logic signed [DATA_W-1:0]  w_res;
   logic                      w_take;

   assign w_x    = $signed(mem_if.x_rd_data);
   assign w_res  = act(sat_shift(r_acc[r_j]), r_relu_en);
   assign w_take = (r_j == '0) || (w_res > r_best);

   // Unpack the per-neuron weight and bias lanes from the wide read words.
   always_comb begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
         w_w[i] = $signed(mem_if.w_rd_data[i*DATA_W +: DATA_W]);
         w_b[i] = $signed(mem_if.b_rd_data[i*DATA_W +: DATA_W]);
      end
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next-state sequencing: IDLE -> BIAS -> MAC -> DRAIN -> WRITE -> DONE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_BIAS;
         S_BIAS:  w_next = (r_n == '0) ? S_DRAIN : S_MAC;
         S_MAC:   if (r_k == r_n - NI_W'(1)) w_next = S_DRAIN;
         S_DRAIN: w_next = S_WRITE;
         S_WRITE: if (r_j == LAST_J) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Strobes and addresses decoded from state; everything is 0 outside its phase.
   always_comb begin
      mem_if.rd_en     = 1'b0;
      mem_if.x_rd_addr = '0;
      mem_if.w_rd_addr = '0;
      mem_if.b_rd_en   = 1'b0;
      mem_if.b_rd_addr = '0;
      mem_if.wr_en     = 1'b0;
      mem_if.wr_addr   = '0;
      mem_if.wr_data   = '0;
      case (r_state)
         S_BIAS: begin
            mem_if.b_rd_en   = 1'b1;
            mem_if.b_rd_addr = r_b_base;
         end
         S_MAC: begin
            mem_if.rd_en     = 1'b1;
            mem_if.x_rd_addr = r_x_base + ADDR_W'(r_k);
            mem_if.w_rd_addr = r_w_base + ADDR_W'(r_k);
         end
         S_WRITE: begin
            mem_if.wr_en   = 1'b1;
            mem_if.wr_addr = r_out_base + ADDR_W'(r_j);
            mem_if.wr_data = w_res;
         end
         default: ;
      endcase
   end

   assign o_busy      = (r_state != S_IDLE);
   assign o_done      = (r_state == S_DONE);
   assign o_class_idx = r_class_idx;

   // Operand latch on an accepted start, plus the input (k) and output (j) counters.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_n        <= '0;
         r_relu_en  <= 1'b0;
         r_x_base   <= '0;
         r_w_base   <= '0;
         r_b_base   <= '0;
         r_out_base <= '0;
         r_k        <= '0;
         r_j        <= '0;
      end else begin
         if (r_state == S_IDLE && i_start) begin
            r_n        <= i_n_inputs;
            r_relu_en  <= i_relu_en;
            r_x_base   <= i_x_base;
            r_w_base   <= i_w_base;
            r_b_base   <= i_b_base;
            r_out_base <= i_out_base;
         end
         case (r_state)
            S_BIAS:  r_k <= '0;
            S_MAC:   r_k <= r_k + NI_W'(1);
            S_DRAIN: r_j <= '0;
            S_WRITE: r_j <= r_j + CI_W'(1);
            default: ;
         endcase
      end
   end

   // Read-data valid flags, one cycle behind the read strobes.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld_p1  <= 1'b0;
         r_bvld_p1 <= 1'b0;
      end else begin
         r_vld_p1  <= (r_state == S_MAC);
         r_bvld_p1 <= (r_state == S_BIAS);
      end
   end

   // Accumulators: seeded with the scaled bias, then one MAC per valid operand.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_NEURONS; i++) r_acc[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            if (r_bvld_p1)     r_acc[i] <= bias_ext(w_b[i]);
            else if (r_vld_p1) r_acc[i] <= r_acc[i] + mac_term(w_x, w_w[i]);
         end
      end
   end

   // Running argmax over the written results; strict compare keeps the lower index on ties.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_best      <= '0;
         r_best_idx  <= '0;
         r_class_idx <= '0;
      end else if (r_state == S_WRITE) begin
         if (w_take) begin
            r_best     <= w_res;
            r_best_idx <= r_j;
         end
         if (r_j == LAST_J) r_class_idx <= w_take ? r_j : r_best_idx;
      end
   end
endmodule

// File: tb/tb_dense_layer_engine.sv
// Scoreboard bench for dense_layer_engine: stimulus pushes expected writes
// and done events, a negedge monitor pops and compares them.
module tb_dense_layer_engine;
   localparam int DW = 16, NN = 10, AW = 16, NI_W = 10, CI_W = 4;
   localparam logic [AW-1:0] X_BASE = 16'h1000, W_BASE = 16'h2000;
   localparam logic [AW-1:0] B_BASE = 16'h0302, O_BASE = 16'h3000;

   logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0, relu = 1'b0;
   logic [NI_W-1:0] n_in = '0;
   logic            busy, done;
   logic [CI_W-1:0] cls;
   int              cyc = 0, n_cmp = 0, n_fail = 0;

   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
   typedef struct { int c; int cls; } dn_t;
   wr_t wr_q[$];
   dn_t dn_q[$];

   logic [DW-1:0]    xmem [1024];
   logic [NN*DW-1:0] wmem [1024];
   logic [NN*DW-1:0] bmem [4];

   dense_layer_engine_if #(.DATA_W(DW), .NUM_NEURONS(NN), .ADDR_W(AW)) mif ();

   dense_layer_engine dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_n_inputs(n_in), .i_relu_en(relu),
      .i_x_base(X_BASE), .i_w_base(W_BASE), .i_b_base(B_BASE), .i_out_base(O_BASE),
      .mem_if(mif), .o_busy(busy), .o_done(done), .o_class_idx(cls)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Registered memory, one cycle read latency.
   always @(posedge clk) begin
      if (mif.rd_en) begin
         mif.x_rd_data <= xmem[mif.x_rd_addr[9:0]];
         mif.w_rd_data <= wmem[mif.w_rd_addr[9:0]];
      end
      if (mif.b_rd_en) mif.b_rd_data <= bmem[mif.b_rd_addr[1:0]];
   end

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string nm, input longint act);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got %0d (cycle %0d)", nm, act, cyc);
   endtask

   // Monitor: every write and every done must match the head of its queue.
   always @(negedge clk) begin
      if (mif.wr_en) begin
         if (wr_q.size() == 0) fail_now("unexpected_wr_addr", mif.wr_addr);
         else begin
            wr_t e;
            e = wr_q.pop_front();
            check("wr_addr", mif.wr_addr, e.addr);
            check("wr_data", longint'($signed(mif.wr_data)), longint'($signed(e.data)));
         end
      end
      if (done) begin
         if (dn_q.size() == 0) fail_now("unexpected_done_cycle", cyc);
         else begin
            dn_t d;
            d = dn_q.pop_front();
            check("done_cycle", cyc, d.c);
            check("class_idx", cls, d.cls);
            check("busy_at_done", busy, 1);
         end
      end
   end

   task automatic push_wr(input int j, input logic [DW-1:0] d);
      wr_q.push_back('{O_BASE + AW'(j), d});
   endtask

   task automatic push_dn(input int c, input int k);
      dn_q.push_back('{c, k});
   endtask

   task automatic start_run(input int n, input bit r, output int s);
      @(negedge clk);
      n_in = NI_W'(n); relu = r; start = 1'b1; s = cyc;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
   endtask

   task automatic wait_drain(input int maxc, input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk); #1;
         if (wr_q.size() == 0 && dn_q.size() == 0) begin ok = 1'b1; break; end
      end
      if (!ok) fail_now({nm, "_timeout_pending"}, wr_q.size() + dn_q.size());
   endtask

   task automatic fill_basic();
      xmem[0] = 16'd256; xmem[1] = 16'd512;
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < NN; i++) wmem[k][i*DW +: DW] = DW'(256 * i);
      bmem[2] = '0;
   endtask

   task automatic fill_const(input int n, input logic [DW-1:0] xv, input logic [DW-1:0] wv);
      for (int k = 0; k < n; k++) begin
         xmem[k] = xv;
         for (int i = 0; i < NN; i++) wmem[k][i*DW +: DW] = wv;
      end
      bmem[2] = '0;
   endtask

   initial begin
      int s;
      bit found;
      for (int a = 0; a < 1024; a++) begin xmem[a] = 16'h0101; wmem[a] = {NN{16'h0202}}; end
      for (int a = 0; a < 4; a++) bmem[a] = {NN{16'h7F00}};
      mif.x_rd_data = '0; mif.w_rd_data = '0; mif.b_rd_data = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_class", cls, 0);
      check("rst_strobes", {mif.rd_en, mif.b_rd_en, mif.wr_en}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", busy, 0);

      // Basic dot product: 1.0*256i + 2.0*256i = 768i
      fill_basic();
      start_run(2, 1'b0, s);
      for (int i = 0; i < NN; i++) push_wr(i, DW'(768 * i));
      push_dn(s + 15, 9);
      wait_drain(40, "basic");
      repeat (3) @(negedge clk);
      check("class_held", cls, 9);

      // ReLU and bias only, n=0: even -1.0 -> 0, odd 0.5 -> 128, tie -> class 1
      for (int i = 0; i < NN; i++) bmem[2][i*DW +: DW] = (i % 2 == 0) ? 16'hFF00 : 16'h0080;
      start_run(0, 1'b1, s);
      for (int i = 0; i < NN; i++) push_wr(i, (i % 2 == 0) ? 16'h0000 : 16'h0080);
      push_dn(s + 13, 1);
      wait_drain(40, "relu_bias");

      // Saturation high: 4 * 127.0 * 127.0 -> 32767
      fill_const(4, 16'd32512, 16'd32512);
      start_run(4, 1'b0, s);
      for (int i = 0; i < NN; i++) push_wr(i, 16'h7FFF);
      push_dn(s + 17, 0);
      wait_drain(40, "sat_pos");

      // Saturation low: -32768 without ReLU, 0 with ReLU
      fill_const(4, 16'd32512, 16'h8100);
      start_run(4, 1'b0, s);
      for (int i = 0; i < NN; i++) push_wr(i, 16'h8000);
      push_dn(s + 17, 0);
      wait_drain(40, "sat_neg");
      start_run(4, 1'b1, s);
      for (int i = 0; i < NN; i++) push_wr(i, 16'h0000);
      push_dn(s + 17, 0);
      wait_drain(40, "sat_neg_relu");

      // Busy protection and back-to-back runs with start held high
      fill_const(4, 16'd32512, 16'd32512);
      @(negedge clk);
      n_in = NI_W'(4); relu = 1'b0; start = 1'b1; s = cyc;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < NN; i++) push_wr(i, 16'h7FFF);
      push_dn(s + 17, 0);
      @(negedge clk);
      @(negedge clk); start = 1'b1;          // inside MAC, must be ignored
      @(negedge clk); start = 1'b0;
      check("busy_in_mac", busy, 1);
      while (cyc < s + 10) @(negedge clk);
      start = 1'b1;
      for (int i = 0; i < NN; i++) push_wr(i, 16'h7FFF);
      push_dn(s + 18 + 17, 0);
      while (cyc < s + 18) @(negedge clk);
      check("b2b_idle_gap_busy", busy, 0);
      @(negedge clk);
      check("b2b_second_busy", busy, 1);
      start = 1'b0;
      wait_drain(60, "busy_prot");

      // Reset in the middle of WRITE (j=4)
      fill_basic();
      start_run(2, 1'b0, s);
      for (int i = 0; i < NN; i++) push_wr(i, DW'(768 * i));
      push_dn(s + 15, 9);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #2;
         if (mif.wr_en && mif.wr_addr == O_BASE + AW'(4)) begin found = 1'b1; break; end
      end
      if (!found) fail_now("reset_run_no_j4_write", wr_q.size());
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_class", cls, 0);
      check("midrst_strobes", {mif.rd_en, mif.b_rd_en, mif.wr_en}, 0);
      check("midrst_wr_bus", {mif.wr_addr, mif.wr_data}, 0);
      check("midrst_pending_writes", wr_q.size(), 5);
      wr_q.delete();
      dn_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("postrst_class", cls, 0);
      start_run(2, 1'b0, s);
      for (int i = 0; i < NN; i++) push_wr(i, DW'(768 * i));
      push_dn(s + 15, 9);
      wait_drain(40, "post_reset");

      // Full depth: 784 * (1 LSB * 1 LSB) >> 8 = 3
      fill_const(784, 16'd1, 16'd1);
      start_run(784, 1'b0, s);
      for (int i = 0; i < NN; i++) push_wr(i, 16'd3);
      push_dn(s + 797, 0);
      wait_drain(900, "full_depth");

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end
endmodule
